// File: rtl/ca_pkg.sv
// Shared types and constants for the cellular-automaton rule sequencer.
package ca_pkg;

    localparam int RULE_W  = 8;
    localparam int COLOR_W = 6;

    localparam logic [RULE_W-1:0] RULE_TABLE [0:7] = '{
        8'd30, 8'd110, 8'd22, 8'd73, 8'd90, 8'd146, 8'd105, 8'd102
    };

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_PEND,
        PRESSED,
        REL_PEND
    } btn_state_t;

    // A rule with nothing in bits [6:1] would draw black live cells; force white instead.
    function automatic logic [COLOR_W-1:0] rule_to_color(input logic [RULE_W-1:0] r);
        return (r[6:1] == '0) ? '1 : r[6:1];
    endfunction

endpackage

// File: rtl/ca_btn_debounce.sv
// Button synchronizer plus a debounce FSM that only looks at the button on frame ticks.
//
// state      | meaning
// RELEASED   | button idle
// PRESS_PEND | seen high on one frame tick, waiting for confirmation
// PRESSED    | press confirmed (event already emitted)
// REL_PEND   | seen low once while pressed, waiting for confirmation
module ca_btn_debounce
    import ca_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic frame_tick,
    input  logic btn,
    output logic press
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   btn_s;
    btn_state_t             state_q;
    btn_state_t             state_d;

    assign btn_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q  <= '0;
            state_q <= RELEASED;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], btn};
            state_q <= state_d;
        end
    end

    // press is combinational so the consumer acts on the same frame tick edge.
    always_comb begin
        state_d = state_q;
        press   = 1'b0;
        if (frame_tick) begin
            case (state_q)
                RELEASED:   if (btn_s) state_d = PRESS_PEND;
                PRESS_PEND: begin
                    if (btn_s) begin
                        state_d = PRESSED;
                        press   = 1'b1;
                    end else begin
                        state_d = RELEASED;
                    end
                end
                PRESSED:    if (!btn_s) state_d = REL_PEND;
                REL_PEND:   state_d = btn_s ? PRESSED : RELEASED;
                default:    state_d = RELEASED;
            endcase
        end
    end

endmodule

// File: rtl/ca_rule_sequencer.sv
// Selects the Wolfram rule and live-cell colour per screen band; state moves only on frame ticks.
module ca_rule_sequencer
    import ca_pkg::*;
#(
    parameter  int NUM_RULES   = 8,
    parameter  int AUTO_FRAMES = 64,
    parameter  int SYNC_STAGES = 2,
    localparam int IW          = $clog2(NUM_RULES)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frame_tick,
    input  logic               band_tick,
    input  logic               btn_next,
    input  logic               btn_prev,
    input  logic               sw_auto,
    input  logic               sw_custom,
    input  logic [RULE_W-1:0]  custom_rule,
    output logic [RULE_W-1:0]  rule,
    output logic [COLOR_W-1:0] rule_color,
    output logic [IW-1:0]      base_idx,
    output logic [IW-1:0]      band_idx
);

    localparam int            FW         = (AUTO_FRAMES > 2) ? $clog2(AUTO_FRAMES) : 1;
    localparam logic [FW-1:0] FRAME_LOAD = FW'(AUTO_FRAMES - 1);

    logic [SYNC_STAGES-1:0] auto_sq;
    logic [SYNC_STAGES-1:0] cust_sq;
    logic [RULE_W-1:0]      crule_sq [SYNC_STAGES];
    logic                   auto_s;
    logic                   cust_s;
    logic [RULE_W-1:0]      crule_s;

    logic                   next_ev;
    logic                   prev_ev;
    logic                   single_ev;
    logic                   auto_adv;

    logic [IW-1:0]          band_cnt;
    logic [IW-1:0]          base_q;
    logic [FW-1:0]          frame_rem;
    logic                   cust_en;
    logic [RULE_W-1:0]      cust_rule;

    logic [IW-1:0]          idx_sum;
    logic [RULE_W-1:0]      rule_d;

    assign auto_s  = auto_sq[SYNC_STAGES-1];
    assign cust_s  = cust_sq[SYNC_STAGES-1];
    assign crule_s = crule_sq[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            auto_sq <= '0;
            cust_sq <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) crule_sq[i] <= '0;
        end else begin
            auto_sq     <= {auto_sq[SYNC_STAGES-2:0], sw_auto};
            cust_sq     <= {cust_sq[SYNC_STAGES-2:0], sw_custom};
            crule_sq[0] <= custom_rule;
            for (int i = 1; i < SYNC_STAGES; i++) crule_sq[i] <= crule_sq[i-1];
        end
    end

    ca_btn_debounce #(.SYNC_STAGES(SYNC_STAGES)) u_next (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_tick (frame_tick),
        .btn        (btn_next),
        .press      (next_ev)
    );

    ca_btn_debounce #(.SYNC_STAGES(SYNC_STAGES)) u_prev (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_tick (frame_tick),
        .btn        (btn_prev),
        .press      (prev_ev)
    );

    assign single_ev = next_ev ^ prev_ev;
    assign auto_adv  = !next_ev && !prev_ev && auto_s && (frame_rem == '0);

    // frame_rem counts down the frames left before an auto advance; FRAME_LOAD means none elapsed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            band_cnt  <= '0;
            base_q    <= '0;
            frame_rem <= FRAME_LOAD;
            cust_en   <= 1'b0;
            cust_rule <= '0;
        end else begin
            if (frame_tick) begin
                band_cnt <= '0;
            end else if (band_tick) begin
                band_cnt <= band_cnt + 1'b1;
            end

            if (frame_tick) begin
                cust_en   <= cust_s;
                cust_rule <= crule_s;
                if (next_ev && !prev_ev) begin
                    base_q <= base_q + 1'b1;
                end else if (prev_ev && !next_ev) begin
                    base_q <= base_q - 1'b1;
                end else if (auto_adv) begin
                    base_q <= base_q + 1'b1;
                end
            end

            if (!auto_s || (frame_tick && (single_ev || frame_rem == '0))) begin
                frame_rem <= FRAME_LOAD;
            end else if (frame_tick) begin
                frame_rem <= frame_rem - 1'b1;
            end
        end
    end

    assign idx_sum  = base_q + band_cnt;
    assign rule_d   = cust_en ? cust_rule : RULE_TABLE[idx_sum];
    assign base_idx = base_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rule       <= RULE_TABLE[0];
            rule_color <= rule_to_color(RULE_TABLE[0]);
            band_idx   <= '0;
        end else begin
            rule       <= rule_d;
            rule_color <= rule_to_color(rule_d);
            band_idx   <= idx_sum;
        end
    end

endmodule
